reg_bank_scheduler: RTL and testbench
=====================================

Name: reg_bank_scheduler

Overview:
- Sequences and shares the 32x32 register bank (BancoRegistradores) of the single-cycle processor.
- After reset, zero-fills R1..R31.
- Then arbitrates the bank between the core datapath (priority) and a debug port with valid/ready handshake. Starvation-bounded: the debug port preempts the core by stalling it for one cycle.
- Sits between the core's register-file fields, the debug unit and the bank ports.

Parameters:
- NUM_REGS, 32, register count; R0 is hardwired zero.
- ADDR_W, 5, register address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, maximum cycles a pending debug request waits while the core is active.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- core_active  in  1  core issuing an instruction this cycle.
- core_regWrite  in  1  core write enable.
- core_regEscrita  in  ADDR_W  core write address.
- core_DadosEscrita  in  DATA_W  core write data.
- core_regLeitura1  in  ADDR_W  core read address 1.
- core_regLeitura2  in  ADDR_W  core read address 2.
- core_stall  out  1  core must hold its PC/state this cycle.
- init_done  out  1  zero-fill finished.
- dbg_valid  in  1  debug request pending.
- dbg_write  in  1  1 = write, 0 = read.
- dbg_addr  in  ADDR_W  debug register address.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_ready  out  1  debug request accepted this cycle.
- dbg_rdata  out  DATA_W  registered debug read data.
- dbg_rvalid  out  1  one-cycle pulse, dbg_rdata valid.
- regWrite  out  1  to bank.
- regEscrita  out  ADDR_W  to bank.
- DadosEscrita  out  DATA_W  to bank.
- regLeitura1  out  ADDR_W  to bank.
- regLeitura2  out  ADDR_W  to bank.
- DadosLeitura2  in  DATA_W  from bank, read port 2.

Behaviour:
- Reset values: state=CLEAR, clear pointer=1, starvation counter=0, core_stall=1, init_done=0, dbg_ready=0, dbg_rvalid=0, dbg_rdata=0, regWrite=0.
- Reset asserted mid-operation aborts any transaction immediately. No dbg_rvalid is issued for a request accepted in the cycle reset rises.

CLEAR state:
- regWrite=1, regEscrita=pointer, DadosEscrita=0; pointer increments each Clock.
- After writing R(NUM_REGS-1), i.e. 31 cycles, go to RUN and set init_done=1 (registered).
- core_stall=1 and dbg_ready=0 throughout.

RUN state, grant (combinational from current inputs/counter):
- Debug is granted when dbg_valid && (!core_active || counter==STARVE_LIMIT).
- Otherwise the core owns the bank.

RUN state, core owns the bank:
- Bank ports mirror the core_* signals; core_stall=0.
- counter increments while dbg_valid is pending and not granted, saturating at STARVE_LIMIT.

RUN state, debug granted:
- dbg_ready=1 and counter clears to 0.
- core_stall=core_active.
- Core write is suppressed: regWrite is driven only by debug.
- regLeitura1 still mirrors the core; regLeitura2=dbg_addr.

Debug write:
- regWrite=1, regEscrita=dbg_addr, DadosEscrita=dbg_wdata.
- Writes to R0 are acknowledged normally; the bank ignores them.

Debug read:
- regWrite=0.
- DadosLeitura2 is captured into dbg_rdata at the grant edge; dbg_rvalid pulses in the following cycle (latency 1).

Handshake:
- A transfer occurs on dbg_valid && dbg_ready.
- The requester holds dbg_write/addr/wdata stable while valid && !ready.
- Back-to-back debug requests are legal.
- Each granted debug transfer resets the counter, so the core regains the bank for at least one cycle before the next starvation grant.

Bounds:
- Worst-case debug wait is STARVE_LIMIT cycles.
- The core stalls at most 1 in every STARVE_LIMIT+1 cycles.

Simultaneous core and debug write to the same address: the debug write wins, and the core is stalled and re-issues its write next cycle.

Decomposition:
- Package reg_bank_pkg: ADDR_W, DATA_W, NUM_REGS, state encoding (CLEAR, RUN), and the R0 constant.
- Sub-module reg_bank_clear_seq: pointer counter, done flag, and the write outputs for CLEAR.
- Arbitration, counter and port muxing stay in the top level.

Test Plan:
1. Reset, then release → regWrite=1 for 31 consecutive cycles with regEscrita 1..31 and DadosEscrita=0; init_done=1 afterwards; reading R5 returns 0.
2. core_active=0, debug write 192 to R5, then debug read R5 → dbg_ready=1 on the first cycle of each request; dbg_rvalid one cycle after the read grant with dbg_rdata=192; core_stall=0.
3. core_active=1 continuously, dbg_valid=1 read R7 → dbg_ready rises on the 5th cycle (STARVE_LIMIT=4 wait); core_stall=1 in exactly that cycle; counter back to 0.
4. Debug write 999 to R0, then debug read R0 → handshake completes and dbg_rdata=0.
5. Core writes 0xAAAA to R3 while a starved debug write of 0x5555 to R3 is granted → the bank sees only 0x5555 that cycle; core_stall=1; the core's re-issue next cycle leaves R3=0xAAAA.
6. Reset asserted at CLEAR pointer=12 and again during a debug read grant → outputs return to reset values asynchronously; CLEAR restarts at R1; no dbg_rvalid pulse appears.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared constants and state encoding for the register-bank scheduler.
package reg_bank_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    // R0 is hardwired to zero inside the bank itself.
    localparam logic [ADDR_W-1:0] R0       = '0;
    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } sched_state_t;

endpackage : reg_bank_pkg

// File: rtl/reg_bank_clear_seq.sv
// Post-reset zero-fill sequencer: walks R1..R(NUM_REGS-1), writing 0 to each.
module reg_bank_clear_seq
    import reg_bank_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    output logic              clrWrite,
    output logic [ADDR_W-1:0] clrAddr,
    output logic [DATA_W-1:0] clrData,
    output logic              clrLast,
    output logic              clrDone
);

    logic [ADDR_W-1:0] pointer;
    logic              done;

    // Pointer advances once per cycle until the last register has been written.
    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pointer <= ADDR_W'(1);
            done    <= 1'b0;
        end else if (!done) begin
            if (pointer == LAST_REG) begin
                done <= 1'b1;
            end else begin
                pointer <= pointer + ADDR_W'(1);
            end
        end
    end

    assign clrWrite = !done;
    assign clrAddr  = pointer;
    assign clrData  = '0;
    assign clrLast  = !done && (pointer == LAST_REG);
    assign clrDone  = done;

endmodule : reg_bank_clear_seq

// File: rtl/reg_bank_scheduler.sv
// Shares the register bank between the core datapath and a debug port,
// after first zero-filling R1..R31. The core has priority, but a pending
// debug request is granted after at most STARVE_LIMIT cycles of waiting.
module reg_bank_scheduler
    import reg_bank_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
)
(
    input  logic              Clock,
    input  logic              Reset,
    // core side
    input  logic              core_active,
    input  logic              core_regWrite,
    input  logic [ADDR_W-1:0] core_regEscrita,
    input  logic [DATA_W-1:0] core_DadosEscrita,
    input  logic [ADDR_W-1:0] core_regLeitura1,
    input  logic [ADDR_W-1:0] core_regLeitura2,
    output logic              core_stall,
    output logic              init_done,
    // debug side
    input  logic              dbg_valid,
    input  logic              dbg_write,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ready,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_rvalid,
    // bank side
    output logic              regWrite,
    output logic [ADDR_W-1:0] regEscrita,
    output logic [DATA_W-1:0] DadosEscrita,
    output logic [ADDR_W-1:0] regLeitura1,
    output logic [ADDR_W-1:0] regLeitura2,
    input  logic [DATA_W-1:0] DadosLeitura2
);

    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    sched_state_t      state;
    sched_state_t      nextState;
    logic [CNT_W-1:0]  starveCnt;
    logic              dbgGrant;
    logic              dbgReadGrant;

    logic              clrWrite;
    logic [ADDR_W-1:0] clrAddr;
    logic [DATA_W-1:0] clrData;
    logic              clrLast;
    logic              clrDone;

    reg_bank_clear_seq u_clear_seq (
        .Clock    (Clock),
        .Reset    (Reset),
        .clrWrite (clrWrite),
        .clrAddr  (clrAddr),
        .clrData  (clrData),
        .clrLast  (clrLast),
        .clrDone  (clrDone)
    );

    // Debug wins when the core is idle, or when it has waited out the starvation limit.
    // Gated with Reset so a grant can never be seen while reset is asserted.
    assign dbgGrant     = !Reset && (state == RUN) && dbg_valid &&
                          (!core_active || (starveCnt == CNT_MAX));
    assign dbgReadGrant = dbgGrant && !dbg_write;

    assign init_done = clrDone;

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= CLEAR;
        end else begin
            state <= nextState;
        end
    end

    // Next state: leave CLEAR once the last register is being written.
    always_comb begin
        nextState = state;
        if ((state == CLEAR) && clrLast) begin
            nextState = RUN;
        end
    end

    // Starvation counter: counts cycles a debug request waits behind the core.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            starveCnt <= '0;
        end else if ((state != RUN) || dbgGrant || !dbg_valid) begin
            starveCnt <= '0;
        end else if (starveCnt != CNT_MAX) begin
            starveCnt <= starveCnt + CNT_W'(1);
        end
    end

    // Debug read data is captured at the grant edge and flagged one cycle later.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            dbg_rdata  <= '0;
            dbg_rvalid <= 1'b0;
        end else begin
            dbg_rvalid <= dbgReadGrant;
            if (dbgReadGrant) begin
                dbg_rdata <= DadosLeitura2;
            end
        end
    end

    // Output mux: clear sequencer, core pass-through, or debug override.
    // Reset forces the quiet values combinationally so the bank stops writing at once.
    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        core_stall   = 1'b1;
        dbg_ready    = 1'b0;
        regWrite     = 1'b0;
        regEscrita   = core_regEscrita;
        DadosEscrita = core_DadosEscrita;
        regLeitura1  = core_regLeitura1;
        regLeitura2  = core_regLeitura2;
        if (!Reset) begin
            case (state)
                CLEAR: begin
                    regWrite     = clrWrite;
                    regEscrita   = clrAddr;
                    DadosEscrita = clrData;
                end
                RUN: begin
                    if (dbgGrant) begin
                        // Core write is dropped; the stalled core re-issues it next cycle.
                        dbg_ready    = 1'b1;
                        core_stall   = core_active;
                        regWrite     = dbg_write;
                        regEscrita   = dbg_addr;
                        DadosEscrita = dbg_wdata;
                        regLeitura2  = dbg_addr;
                    end else begin
                        core_stall   = 1'b0;
                        regWrite     = core_regWrite;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : reg_bank_scheduler

// File: tb/tb_reg_bank_scheduler.sv
// Directed bench for reg_bank_scheduler with a behavioural 32x32 bank attached.
module tb_reg_bank_scheduler;

    logic        Clock_tb;
    logic        Reset_tb;
    logic        core_active;
    logic        core_regWrite;
    logic [4:0]  core_regEscrita;
    logic [31:0] core_DadosEscrita;
    logic [4:0]  core_regLeitura1;
    logic [4:0]  core_regLeitura2;
    logic        core_stall;
    logic        init_done;
    logic        dbg_valid;
    logic        dbg_write;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ready;
    logic [31:0] dbg_rdata;
    logic        dbg_rvalid;
    logic        regWrite;
    logic [4:0]  regEscrita;
    logic [31:0] DadosEscrita;
    logic [4:0]  regLeitura1;
    logic [4:0]  regLeitura2;
    logic [31:0] DadosLeitura2;

    int testsRun  = 0;
    int failCount = 0;

    // Bank model: unwritten registers read as junk so the zero-fill is visible.
    logic [31:0] bankModel [32];
    bit   [31:0] bankWritten;

    always @(posedge Clock_tb) begin
        if (regWrite && (regEscrita != 5'd0)) begin
            bankModel[regEscrita]   <= DadosEscrita;
            bankWritten[regEscrita] <= 1'b1;
        end
    end

    assign DadosLeitura2 = (regLeitura2 == 5'd0)     ? 32'd0 :
                           bankWritten[regLeitura2] ? bankModel[regLeitura2] : 32'hDEAD_BEEF;

    reg_bank_scheduler dut (
        .Clock             (Clock_tb),
        .Reset             (Reset_tb),
        .core_active       (core_active),
        .core_regWrite     (core_regWrite),
        .core_regEscrita   (core_regEscrita),
        .core_DadosEscrita (core_DadosEscrita),
        .core_regLeitura1  (core_regLeitura1),
        .core_regLeitura2  (core_regLeitura2),
        .core_stall        (core_stall),
        .init_done         (init_done),
        .dbg_valid         (dbg_valid),
        .dbg_write         (dbg_write),
        .dbg_addr          (dbg_addr),
        .dbg_wdata         (dbg_wdata),
        .dbg_ready         (dbg_ready),
        .dbg_rdata         (dbg_rdata),
        .dbg_rvalid        (dbg_rvalid),
        .regWrite          (regWrite),
        .regEscrita        (regEscrita),
        .DadosEscrita      (DadosEscrita),
        .regLeitura1       (regLeitura1),
        .regLeitura2       (regLeitura2),
        .DadosLeitura2     (DadosLeitura2)
    );

    initial Clock_tb = 1'b0;
    always #5 Clock_tb = ~Clock_tb;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge Clock_tb);
        #1;
    endtask

    initial begin
        Reset_tb          = 1'b1;
        core_active       = 1'b0;
        core_regWrite     = 1'b0;
        core_regEscrita   = 5'd0;
        core_DadosEscrita = 32'd0;
        core_regLeitura1  = 5'd2;
        core_regLeitura2  = 5'd4;
        dbg_valid         = 1'b0;
        dbg_write         = 1'b0;
        dbg_addr          = 5'd0;
        dbg_wdata         = 32'd0;

        // ---- reset values
        tick();
        tick();
        check("rst_stall",    {31'd0, core_stall}, 32'd1);
        check("rst_init",     {31'd0, init_done},  32'd0);
        check("rst_ready",    {31'd0, dbg_ready},  32'd0);
        check("rst_rvalid",   {31'd0, dbg_rvalid}, 32'd0);
        check("rst_rdata",    dbg_rdata,           32'd0);
        check("rst_regWrite", {31'd0, regWrite},   32'd0);

        // ---- 1: zero-fill R1..R31
        Reset_tb = 1'b0;
        #1;
        for (int i = 1; i <= 31; i++) begin
            check($sformatf("clr_we_%0d", i),   {31'd0, regWrite},   32'd1);
            check($sformatf("clr_addr_%0d", i), {27'd0, regEscrita}, i);
            check($sformatf("clr_data_%0d", i), DadosEscrita,        32'd0);
            check($sformatf("clr_stall_%0d", i), {31'd0, core_stall}, 32'd1);
            tick();
        end
        check("init_done",     {31'd0, init_done},  32'd1);
        check("run_idle_we",   {31'd0, regWrite},   32'd0);
        check("run_idle_stall", {31'd0, core_stall}, 32'd0);

        dbg_valid = 1'b1; dbg_write = 1'b0; dbg_addr = 5'd5;
        #1;
        check("rdR5_ready", {31'd0, dbg_ready},  32'd1);
        check("rdR5_rl2",   {27'd0, regLeitura2}, 32'd5);
        tick();
        dbg_valid = 1'b0;
        check("rdR5_rvalid", {31'd0, dbg_rvalid}, 32'd1);
        check("rdR5_rdata",  dbg_rdata,           32'd0);
        tick();
        check("rdR5_rvalid_off", {31'd0, dbg_rvalid}, 32'd0);

        // ---- 2: idle core, debug write 192 to R5 then read back
        dbg_valid = 1'b1; dbg_write = 1'b1; dbg_addr = 5'd5; dbg_wdata = 32'd192;
        #1;
        check("wr5_ready", {31'd0, dbg_ready},  32'd1);
        check("wr5_we",    {31'd0, regWrite},   32'd1);
        check("wr5_addr",  {27'd0, regEscrita}, 32'd5);
        check("wr5_data",  DadosEscrita,        32'd192);
        check("wr5_stall", {31'd0, core_stall}, 32'd0);
        tick();
        dbg_write = 1'b0;
        #1;
        check("rd5_ready", {31'd0, dbg_ready}, 32'd1);
        check("rd5_we",    {31'd0, regWrite},  32'd0);
        tick();
        dbg_valid = 1'b0;
        check("rd5_rvalid", {31'd0, dbg_rvalid}, 32'd1);
        check("rd5_rdata",  dbg_rdata,           32'd192);

        // Seed R7 for the starvation read.
        dbg_valid = 1'b1; dbg_write = 1'b1; dbg_addr = 5'd7; dbg_wdata = 32'h77;
        #1;
        check("wr7_ready", {31'd0, dbg_ready}, 32'd1);
        tick();
        dbg_valid = 1'b0;

        // ---- 4: write to R0 is acknowledged, reads back 0
        dbg_valid = 1'b1; dbg_write = 1'b1; dbg_addr = 5'd0; dbg_wdata = 32'd999;
        #1;
        check("wr0_ready", {31'd0, dbg_ready}, 32'd1);
        tick();
        dbg_write = 1'b0;
        #1;
        check("rd0_ready", {31'd0, dbg_ready}, 32'd1);
        tick();
        dbg_valid = 1'b0;
        check("rd0_rvalid", {31'd0, dbg_rvalid}, 32'd1);
        check("rd0_rdata",  dbg_rdata,           32'd0);
        tick();

        // ---- 3: busy core, debug read R7 waits STARVE_LIMIT cycles
        core_active = 1'b1;
        dbg_valid = 1'b1; dbg_write = 1'b0; dbg_addr = 5'd7;
        for (int c = 1; c <= 4; c++) begin
            #1;
            check($sformatf("starve_rd_ready_%0d", c), {31'd0, dbg_ready},   32'd0);
            check($sformatf("starve_rd_stall_%0d", c), {31'd0, core_stall},  32'd0);
            check($sformatf("starve_rd_rl2_%0d", c),   {27'd0, regLeitura2}, 32'd4);
            tick();
        end
        #1;
        check("starve_rd_ready5", {31'd0, dbg_ready},   32'd1);
        check("starve_rd_stall5", {31'd0, core_stall},  32'd1);
        check("starve_rd_rl1",    {27'd0, regLeitura1}, 32'd2);
        check("starve_rd_rl2",    {27'd0, regLeitura2}, 32'd7);
        tick();

        // ---- 5: back-to-back starved debug write collides with a core write to R3
        dbg_write = 1'b1; dbg_addr = 5'd3; dbg_wdata = 32'h5555;
        check("starve_rd_rvalid", {31'd0, dbg_rvalid}, 32'd1);
        check("starve_rd_rdata",  dbg_rdata,           32'h77);
        for (int c = 1; c <= 4; c++) begin
            #1;
            check($sformatf("starve_wr_ready_%0d", c), {31'd0, dbg_ready}, 32'd0);
            tick();
        end
        core_regWrite = 1'b1; core_regEscrita = 5'd3; core_DadosEscrita = 32'hAAAA;
        #1;
        check("collide_ready", {31'd0, dbg_ready},  32'd1);
        check("collide_stall", {31'd0, core_stall}, 32'd1);
        check("collide_we",    {31'd0, regWrite},   32'd1);
        check("collide_addr",  {27'd0, regEscrita}, 32'd3);
        check("collide_data",  DadosEscrita,        32'h5555);
        tick();
        dbg_valid = 1'b0;
        check("collide_bank", bankModel[3], 32'h5555);
        #1;
        check("reissue_stall", {31'd0, core_stall}, 32'd0);
        check("reissue_data",  DadosEscrita,        32'hAAAA);
        tick();
        core_regWrite = 1'b0;
        core_active   = 1'b0;
        dbg_valid = 1'b1; dbg_write = 1'b0; dbg_addr = 5'd3;
        #1;
        check("rd3_ready", {31'd0, dbg_ready}, 32'd1);
        tick();
        dbg_valid = 1'b0;
        check("rd3_rdata", dbg_rdata, 32'hAAAA);
        tick();

        // ---- 6a: reset during a debug read grant
        dbg_valid = 1'b1; dbg_write = 1'b0; dbg_addr = 5'd3;
        #1;
        check("rstgrant_ready_pre", {31'd0, dbg_ready}, 32'd1);
        Reset_tb = 1'b1;
        #1;
        check("rstgrant_ready",  {31'd0, dbg_ready},  32'd0);
        check("rstgrant_rdata",  dbg_rdata,           32'd0);
        check("rstgrant_stall",  {31'd0, core_stall}, 32'd1);
        check("rstgrant_init",   {31'd0, init_done},  32'd0);
        tick();
        dbg_valid = 1'b0;
        check("rstgrant_rvalid", {31'd0, dbg_rvalid}, 32'd0);
        Reset_tb = 1'b0;
        #1;
        check("rstgrant_restart", {27'd0, regEscrita}, 32'd1);
        tick();
        check("rstgrant_rvalid2", {31'd0, dbg_rvalid}, 32'd0);

        // ---- 6b: reset in CLEAR with pointer at 12
        for (int c = 0; c < 10; c++) tick();
        check("clr_ptr12", {27'd0, regEscrita}, 32'd12);
        Reset_tb = 1'b1;
        #1;
        check("clr_rst_we",    {31'd0, regWrite},   32'd0);
        check("clr_rst_stall", {31'd0, core_stall}, 32'd1);
        tick();
        Reset_tb = 1'b0;
        #1;
        check("clr_restart_addr", {27'd0, regEscrita}, 32'd1);
        check("clr_restart_we",   {31'd0, regWrite},   32'd1);
        for (int c = 0; c < 31; c++) tick();
        check("clr2_init_done", {31'd0, init_done}, 32'd1);
        check("clr2_we_off",    {31'd0, regWrite},  32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule : tb_reg_bank_scheduler
